load_use_hazard_unit: RTL

Producer of LU_HAZ_SIG for the pipeline flush unit. It tracks in-flight load instructions in the ID/EX and later stages, and compares their destination registers against the source registers of the instruction in ID. When the ID instruction would read a value that is not yet loaded, it raises a hazard so the flush unit holds IF/ID and bubbles ID/EX. It also keeps a saturating stall-cycle performance counter.

---
 rtl/load_use_hazard_unit.sv | 77 +++++++
 1 files changed

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detector: tracks in-flight loads from ID/EX onward and stalls
// an ID instruction that reads a register whose load data is not yet forwardable.
module load_use_hazard_unit #(
  parameter int LOAD_LATENCY = 1,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   ID_VALID,
  input  logic [4:0]             ID_RS1_ADDR,
  input  logic                   ID_RS1_USE,
  input  logic [4:0]             ID_RS2_ADDR,
  input  logic                   ID_RS2_USE,
  input  logic [4:0]             ID_RD_ADDR,
  input  logic                   ID_MEM_READ,
  input  logic                   BJ_SIG,
  input  logic                   MEM_STALL,
  output logic                   LU_HAZ_SIG,
  output logic                   EX_LOAD_PENDING,
  output logic [COUNT_WIDTH-1:0] STALL_COUNT
);

  logic [LOAD_LATENCY-1:0]      valid_q, valid_d;
  logic [LOAD_LATENCY-1:0][4:0] rd_q, rd_d;
  logic [COUNT_WIDTH-1:0]       count_q, count_d;
  logic [LOAD_LATENCY-1:0]      match;

  genvar gi;
  generate
    for (gi = 0; gi < LOAD_LATENCY; gi++) begin : g_match
      assign match[gi] = valid_q[gi] &&
                         ((ID_RS1_USE && (ID_RS1_ADDR == rd_q[gi])) ||
                          (ID_RS2_USE && (ID_RS2_ADDR == rd_q[gi])));
    end
  endgenerate

  // A branch/jump flushes the ID instruction, so a match then is irrelevant.
  assign LU_HAZ_SIG      = ID_VALID && !BJ_SIG && (|match);
  assign EX_LOAD_PENDING = valid_q[0];
  assign STALL_COUNT     = count_q;

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (!MEM_STALL) begin
      for (int k = 1; k < LOAD_LATENCY; k++) begin
        valid_d[k] = valid_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
      // ID/EX gets a bubble on a flush or a stall; loads to x0 are never tracked.
      if (BJ_SIG || LU_HAZ_SIG) begin
        valid_d[0] = 1'b0;
        rd_d[0]    = ID_RD_ADDR;
      end else begin
        valid_d[0] = ID_VALID && ID_MEM_READ && (ID_RD_ADDR != 5'd0);
        rd_d[0]    = ID_RD_ADDR;
      end
      if (LU_HAZ_SIG && (count_q != {COUNT_WIDTH{1'b1}})) begin
        count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      valid_q <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule
